// File: rtl/fifo_row_reader.sv
// Pops one row from the row FIFO head and streams it out word by word, word 0 first.
// Optional rows_done counter is built when FIFO_ROW_READER_CNT_EN is defined.
module fifo_row_reader #(
    parameter int WIDTH    = 32,
    parameter int ROW_SIZE = 3
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               en,
    input  logic [ROW_SIZE-1:0][WIDTH-1:0]     fifo_data,
    input  logic                               fifo_empty,
    output logic                               fifo_re,
    output logic [WIDTH-1:0]                   out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_last,
`ifdef FIFO_ROW_READER_CNT_EN
    output logic [15:0]                        rows_done,
`endif
    output logic                               busy
);

    localparam int IDX_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_SIZE - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                         r_state;
    logic [IDX_W-1:0]               r_idx;
    logic [ROW_SIZE-1:0][WIDTH-1:0] r_row;

    logic w_send;
    logic w_last;
    logic w_xfer;
    logic w_fetch;

    assign w_send = (r_state == S_SEND);
    assign w_last = w_send && (r_idx == LAST_IDX);
    assign w_xfer = w_send && out_ready;
    // A new row is fetched from IDLE, or on the final word's transfer so rows run back-to-back.
    assign w_fetch = !reset && en && !fifo_empty && (!w_send || (w_xfer && w_last));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_row   <= '0;
        end else if (w_fetch) begin
            r_row   <= fifo_data;
            r_idx   <= '0;
            r_state <= S_SEND;
        end else if (w_xfer) begin
            if (w_last) begin
                r_idx   <= '0;
                r_state <= S_IDLE;
            end else begin
                r_idx   <= r_idx + 1'b1;
            end
        end
    end

`ifdef FIFO_ROW_READER_CNT_EN
    logic [15:0] r_rows_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rows_done <= '0;
        end else if (w_xfer && w_last && (r_rows_done != 16'hFFFF)) begin
            r_rows_done <= r_rows_done + 16'd1;
        end
    end

    assign rows_done = r_rows_done;
`endif

    assign fifo_re   = w_fetch;
    assign out_data  = r_row[r_idx];
    assign out_valid = w_send;
    assign out_last  = w_last;
    assign busy      = w_send;

endmodule

// File: doc/fifo_row_reader.md
Name: fifo_row_reader

Overview:
- Read-side companion of the row FIFO. Pops one ROW_SIZE x WIDTH row at a time from the FIFO head, then serializes it onto a word-wide valid/ready stream, word 0 first.
- Marks the last word of each row so downstream splice logic sees row boundaries.
- Sits between the row FIFO output (data_out/empty/re) and the word-stream consumer.

Parameters:
- WIDTH, 32, bits per word; must match the FIFO WIDTH.
- ROW_SIZE, 3, words per row; must be >= 2 and match the FIFO ROW_SIZE.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  fetch enable; low = no new row is popped, and a row already in flight still completes.
- fifo_data  input  [ROW_SIZE-1:0][WIDTH-1:0]  FIFO head row; valid whenever fifo_empty=0 (first-word fall-through).
- fifo_empty  input  1  FIFO empty flag.
- fifo_re  output  1  pop strobe to the FIFO; one pulse = one row consumed.
- out_data  output  WIDTH  current word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the word.
- out_last  output  1  high with the final word (index ROW_SIZE-1) of a row.
- busy  output  1  high while a row is held (state SEND).

Behaviour:
- State machine:
  - IDLE: no row held.
    - If en && !fifo_empty, then fifo_re=1 in the same cycle, fifo_data is captured into the row register, idx<=0, and the next state is SEND.
    - Otherwise stay in IDLE.
  - SEND: out_valid=1 and out_data=row[idx].
    - Transfer occurs when out_valid && out_ready.
    - On a transfer with idx<ROW_SIZE-1: idx<=idx+1.
    - On a transfer with idx==ROW_SIZE-1 (out_last=1):
      - if en && !fifo_empty: fifo_re=1, the next row is captured, idx<=0, and the state stays SEND (back-to-back, no bubble).
      - otherwise the next state is IDLE.
- fifo_re is combinational and is never asserted when fifo_empty=1. In SEND it depends combinationally on out_ready; this path is accepted.
- At most one pop per row; fifo_re is never high in two consecutive cycles unless ROW_SIZE words have been transferred in between (that cannot happen for ROW_SIZE>=2).
- Latency: if the row is at the head in cycle N (IDLE, en=1), fifo_re is high in cycle N and word 0 is valid in cycle N+1. With out_ready held high, a row takes exactly ROW_SIZE cycles.
- Stall: while out_valid && !out_ready, out_data, out_last and idx are held stable.
- idx is $clog2(ROW_SIZE) bits. It resets to 0 after the last word and never exceeds ROW_SIZE-1.
- out_last = (state==SEND) && (idx==ROW_SIZE-1).
- en deasserted mid-row: the current row finishes normally, then the block goes to IDLE. en is only sampled at row fetch points.
- Reset (any state): state=IDLE, idx=0, out_valid=0, out_last=0, busy=0, fifo_re=0, out_data=0, row register cleared. A partially sent row is discarded, because it was already popped and is not re-read.
- fifo_data is only sampled in a cycle where fifo_re=1.

Optional Feature:
- Macro FIFO_ROW_READER_CNT_EN.
- When defined: adds output rows_done [15:0], which counts rows whose last word has transferred. It saturates at 16'hFFFF and resets to 0 on reset.
- When undefined: the port and counter do not exist, and behaviour is otherwise identical.

Test Plan (WIDTH=32, ROW_SIZE=3):
- Reset, then fifo_empty=1 and en=1 for 10 cycles -> fifo_re=0, out_valid=0, busy=0 throughout.
- One row {w0=0x11,w1=0x22,w2=0x33} at the head, out_ready=1 -> fifo_re pulses 1 cycle. Then words 0x11, 0x22, 0x33 appear in 3 consecutive cycles, out_last only on 0x33, then IDLE.
- Two rows queued, out_ready=1 -> 6 consecutive valid words with no bubble. fifo_re is high in the cycle 0x33 transfers. out_last is high on the 3rd and 6th words.
- out_ready=0 for 5 cycles on word 1 -> out_data=0x22 held stable, idx unchanged, no fifo_re. Release -> 0x22 then 0x33 transfer.
- en dropped during word 1 while a second row is queued -> the first row completes, no second pop, the block goes to IDLE. Raising en -> the second row pops.
- reset asserted while word 1 is valid -> next cycle out_valid=0, busy=0. No pop is issued until a new row is fetched, and the old row is not re-emitted. With CNT_EN, rows_done=0.
